// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling stage: permutes the 256-byte S RAM in place using secret_key.
// Optional macro KSA_INIT_EN adds an INIT state that first writes S[n]=n.
module ksa_scheduler #(
  parameter int KEY_BYTES = 3,
  parameter int READ_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sig_start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             mem_out,
  output logic [7:0]             mem_address,
  output logic [7:0]             mem_data,
  output logic                   wren,
  output logic                   t_done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef KSA_INIT_EN
    S_INIT,
`endif
    S_RD_I,
    S_WAIT_I,
    S_CALC_J,
    S_RD_J,
    S_WAIT_J,
    S_WR_I,
    S_WR_J,
    S_INC_I,
    S_DONE
  } state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_i, w_i_next;
  logic [7:0]      r_j, w_j_next;
  logic [KW-1:0]   r_k, w_k_next;
  logic [WW-1:0]   r_wait, w_wait_next;
  logic [7:0]      r_si, w_si_next;
  logic [7:0]      r_sj, w_sj_next;
  logic [7:0]      r_mem_address, w_mem_address;
  logic [7:0]      r_mem_data, w_mem_data;
  logic            r_wren, w_wren;
  logic            r_t_done, w_t_done;
  logic [7:0]      w_key [KEY_BYTES];
  logic [7:0]      w_key_byte;

  // Key byte 0 is the most significant byte of secret_key.
  always_comb begin
    for (int k = 0; k < KEY_BYTES; k++) begin
      w_key[k] = secret_key[8*(KEY_BYTES-1-k) +: 8];
    end
    w_key_byte = w_key[r_k];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_j_next     = r_j;
    w_k_next     = r_k;
    w_wait_next  = r_wait;
    w_si_next    = r_si;
    w_sj_next    = r_sj;

    unique case (r_state)
      S_IDLE: begin
        if (sig_start) begin
          w_i_next    = '0;
          w_j_next    = '0;
          w_k_next    = '0;
          w_wait_next = '0;
`ifdef KSA_INIT_EN
          w_state_next = S_INIT;
`else
          w_state_next = S_RD_I;
`endif
        end
      end
`ifdef KSA_INIT_EN
      S_INIT: begin
        if (r_i == 8'hFF) begin
          w_i_next     = '0;
          w_state_next = S_RD_I;
        end else begin
          w_i_next = r_i + 8'd1;
        end
      end
`endif
      S_RD_I: w_state_next = S_WAIT_I;
      S_WAIT_I: begin
        if (r_wait == WW'(READ_LAT-1)) begin
          w_si_next    = mem_out;
          w_wait_next  = '0;
          w_state_next = S_CALC_J;
        end else begin
          w_wait_next = r_wait + WW'(1);
        end
      end
      S_CALC_J: begin
        w_j_next     = r_j + r_si + w_key_byte;
        w_state_next = S_RD_J;
      end
      S_RD_J: w_state_next = S_WAIT_J;
      S_WAIT_J: begin
        if (r_wait == WW'(READ_LAT-1)) begin
          w_sj_next    = mem_out;
          w_wait_next  = '0;
          w_state_next = S_WR_I;
        end else begin
          w_wait_next = r_wait + WW'(1);
        end
      end
      S_WR_I: w_state_next = S_WR_J;
      S_WR_J: w_state_next = S_INC_I;
      S_INC_I: begin
        if (r_i == 8'hFF) begin
          w_state_next = S_DONE;
        end else begin
          w_i_next     = r_i + 8'd1;
          w_k_next     = (r_k == KW'(KEY_BYTES-1)) ? '0 : r_k + KW'(1);
          w_state_next = S_RD_I;
        end
      end
      S_DONE: if (!sig_start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // RAM-side outputs are decoded from the next state so the registered
    // values line up with the state that owns them.
    w_mem_address = r_mem_address;
    w_mem_data    = r_mem_data;
    w_wren        = 1'b0;
    w_t_done      = (w_state_next == S_DONE);
    case (w_state_next)
`ifdef KSA_INIT_EN
      S_INIT: begin
        w_mem_address = w_i_next;
        w_mem_data    = w_i_next;
        w_wren        = 1'b1;
      end
`endif
      S_RD_I: w_mem_address = w_i_next;
      S_RD_J: w_mem_address = w_j_next;
      S_WR_I: begin
        w_mem_address = w_i_next;
        w_mem_data    = w_sj_next;
        w_wren        = 1'b1;
      end
      S_WR_J: begin
        w_mem_address = w_j_next;
        w_mem_data    = w_si_next;
        w_wren        = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_wait        <= '0;
      r_si          <= '0;
      r_sj          <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_wren        <= 1'b0;
      r_t_done      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_i           <= w_i_next;
      r_j           <= w_j_next;
      r_k           <= w_k_next;
      r_wait        <= w_wait_next;
      r_si          <= w_si_next;
      r_sj          <= w_sj_next;
      r_mem_address <= w_mem_address;
      r_mem_data    <= w_mem_data;
      r_wren        <= w_wren;
      r_t_done      <= w_t_done;
    end
  end

  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign wren        = r_wren;
  assign t_done      = r_t_done;

endmodule

// File: tb/tb_ksa_scheduler.sv
// Self-checking bench for ksa_scheduler: table vectors, random keys against a
// software RC4 KSA model, handshake and asynchronous-reset sequences.
module tb_ksa_scheduler;

`ifdef KSA_INIT_EN
  localparam int LAT = 2817;
  localparam int OFF = 256;
`else
  localparam int LAT = 2561;
  localparam int OFF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_start;
  logic [23:0] secret_key;
  logic [7:0]  mem_out;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        wren;
  logic        t_done;

  ksa_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_start  (sig_start),
    .secret_key (secret_key),
    .mem_out    (mem_out),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .wren       (wren),
    .t_done     (t_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [23:0] key;
    logic [7:0]  a [4];
    logic [7:0]  d [4];
  } vec_t;

  // S RAM with a two-cycle read pipeline; preload is requested by the bench.
  logic [7:0] mem [256];
  logic [7:0] rd_pipe;
  int         pl_mode = 0;
  wr_t        log_q [$];
  wr_t        exp_q [$];
  logic [7:0] ref_s [256];
  int         n_checks = 0;
  int         n_fail   = 0;

  always @(posedge clk) begin
    if (pl_mode == 1) begin
      for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
    end else if (pl_mode == 2) begin
      for (int n = 0; n < 256; n++) mem[n] <= 8'hFF;
    end else if (wren) begin
      mem[mem_address] <= mem_data;
    end
    rd_pipe <= mem[mem_address];
    mem_out <= rd_pipe;
    if (rst_n && wren) log_q.push_back('{addr: mem_address, data: mem_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input int mode);
    @(negedge clk);
    pl_mode = mode;
    @(posedge clk);
    #1;
    pl_mode = 0;
  endtask

  // Software RC4 KSA on ref_s, recording the write pair each swap produces.
  task automatic model_ksa(input logic [23:0] key);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(2-(i%3)) +: 8];
      j  = j + ref_s[i] + kb;
      t  = ref_s[i];
      exp_q.push_back('{addr: 8'(i), data: ref_s[j]});
      exp_q.push_back('{addr: j, data: t});
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic do_run(input logic [23:0] key, input string tag);
    int cyc;
    int bad;
    int n_done;
    bit seen [256];
    exp_q.delete();
    for (int n = 0; n < 256; n++) begin
`ifdef KSA_INIT_EN
      ref_s[n] = 8'(n);
      exp_q.push_back('{addr: 8'(n), data: 8'(n)});
`else
      ref_s[n] = mem[n];
`endif
    end
    model_ksa(key);
    log_q.delete();
    @(negedge clk);
    secret_key = key;
    sig_start  = 1'b1;
    cyc = 0;
    while (cyc < LAT + 50) begin
      @(posedge clk);
      cyc++;
      #1;
      if (t_done) break;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    n_done = log_q.size();
    repeat (20) @(negedge clk);
    check({tag, "_hold_done"}, 32'(t_done), 32'd1);
    check({tag, "_hold_no_write"}, 32'(log_q.size()), 32'(n_done));
    @(negedge clk);
    sig_start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_done"}, 32'(t_done), 32'd0);
    check({tag, "_write_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    bad = 0;
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
      if (log_q[k] != exp_q[k]) bad++;
    check({tag, "_write_seq_bad"}, 32'(bad), 32'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      if (mem[n] !== ref_s[n]) bad++;
      seen[mem[n]] = 1'b1;
    end
    check({tag, "_final_s_bad"}, 32'(bad), 32'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (!seen[n]) bad++;
    check({tag, "_perm_missing"}, 32'(bad), 32'd0);
  endtask

  vec_t tbl [3];

  initial begin
    tbl[0].key = 24'h010203;
    tbl[0].a   = '{8'h00, 8'h01, 8'h01, 8'h03};
    tbl[0].d   = '{8'h01, 8'h00, 8'h03, 8'h00};
    tbl[1].key = 24'h000000;
    tbl[1].a   = '{8'h00, 8'h00, 8'h01, 8'h01};
    tbl[1].d   = '{8'h00, 8'h00, 8'h01, 8'h01};
    tbl[2].key = 24'hFF0000;
    tbl[2].a   = '{8'h00, 8'hFF, 8'h01, 8'h00};
    tbl[2].d   = '{8'hFF, 8'h00, 8'hFF, 8'h01};

    rst_n      = 1'b0;
    sig_start  = 1'b0;
    secret_key = '0;
    preload(1);
    repeat (3) @(negedge clk);
    check("reset_wren", 32'(wren), 32'd0);
    check("reset_done", 32'(t_done), 32'd0);
    check("reset_addr", 32'(mem_address), 32'd0);
    check("reset_data", 32'(mem_data), 32'd0);
    rst_n = 1'b1;
    log_q.delete();
    repeat (10) @(negedge clk);
    check("idle_no_write", 32'(log_q.size()), 32'd0);

    for (int v = 0; v < 3; v++) begin
`ifdef KSA_INIT_EN
      preload(2);
`else
      preload(1);
`endif
      do_run(tbl[v].key, $sformatf("vec%0d", v));
`ifdef KSA_INIT_EN
      begin
        int bad_init = 0;
        for (int n = 0; n < 256 && n < log_q.size(); n++)
          if (log_q[n].addr !== 8'(n) || log_q[n].data !== 8'(n)) bad_init++;
        check($sformatf("vec%0d_init_bad", v), 32'(bad_init), 32'd0);
      end
`endif
      for (int k = 0; k < 4; k++) begin
        if (log_q.size() > OFF + k) begin
          check($sformatf("vec%0d_w%0d_addr", v, k), 32'(log_q[OFF+k].addr), 32'(tbl[v].a[k]));
          check($sformatf("vec%0d_w%0d_data", v, k), 32'(log_q[OFF+k].data), 32'(tbl[v].d[k]));
        end else begin
          check($sformatf("vec%0d_w%0d_present", v, k), 32'(log_q.size()), 32'(OFF + k + 1));
        end
      end
    end

    // Back-to-back runs on the already permuted S; each must restart at i=j=0.
    for (int r = 0; r < 3; r++) begin
      do_run(24'($urandom), $sformatf("rand%0d", r));
      if (log_q.size() > OFF) check($sformatf("rand%0d_restart_i0", r), 32'(log_q[OFF].addr), 32'd0);
      else check($sformatf("rand%0d_restart_present", r), 32'(log_q.size()), 32'(OFF + 1));
    end

    // Asynchronous reset in the middle of a write cycle.
    preload(1);
    @(negedge clk);
    secret_key = 24'($urandom);
    sig_start  = 1'b1;
    repeat (500) @(negedge clk);
    for (int c = 0; c < 20 && !wren; c++) @(negedge clk);
    check("mid_reset_saw_wren", 32'(wren), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_wren", 32'(wren), 32'd0);
    check("mid_reset_done", 32'(t_done), 32'd0);
    check("mid_reset_addr", 32'(mem_address), 32'd0);
    sig_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    repeat (30) @(negedge clk);
    check("post_reset_no_write", 32'(log_q.size()), 32'd0);
    check("post_reset_done", 32'(t_done), 32'd0);
    preload(1);
    do_run(24'h010203, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
